hms_display_driver: RTL and testbench
=====================================

// Module: hms_display_driver
// PURPOSE
//  Consumer of the stopwatch timing interface: takes the binary HMS time word and the
//  half-second/second strobes and drives a 6-digit multiplexed 7-segment display (HH:MM:SS).
//  Converts each field to BCD with a shared sequential double-dabble engine.
//  The colon blinks at 1 Hz. Sits between the timing block and the board display pins.
// PARAMETERS
//  SCAN_DIV        4   clock cycles each digit is held before the scan advances (>=1)
//  SEG_ACTIVE_LOW  1   1: a lit segment/dp drives 0; 0: a lit segment/dp drives 1
// PORTS
//  clock           in   1   system clock
//  reset           in   1   synchronous, active-high
//  hms_time        in   20  {1'b0, hrs[6:0], min[5:0], sec[5:0]}, binary
//  half_sec_pulse  in   1   1-cycle strobe every half second
//  sec_pulse       in   1   1-cycle strobe every second; hms_time is valid on this cycle
//  blank           in   1   1: display dark (all segments off, digit_sel = 0)
//  seg_out         out  7   {g,f,e,d,c,b,a} for the currently selected digit
//  dp_out          out  1   decimal point of the selected digit (used as colon)
//  digit_sel       out  6   one-hot digit enable; bit5 = hours tens (leftmost)
//  bcd_digits      out  24  committed {H1,H0,M1,M0,S1,S0}, 4 bits each
//  bcd_valid       out  1   1-cycle pulse when bcd_digits updates
//  fmt_err         out  1   committed frame had hrs>99, min>59 or sec>59
//  busy            out  1   conversion in progress
// BEHAVIOUR
//  Reset: bcd_digits=0, bcd_valid=0, fmt_err=0, busy=0, seg_out/dp_out=off level,
//   digit_sel=0, scan index=0, divider=0, colon phase=1, request pending=1.
//   Reset mid-conversion aborts the conversion; no commit.
//  Request: set by sec_pulse, or by hms_time != shadow (last captured word) while in IDLE.
//   Single-depth: extra requests during a conversion merge into one pending flag.
//  FSM: IDLE -> CAP (latch hms_time into shadow, 1 cycle) -> CONV_H (7 shifts) ->
//   CONV_M (6) -> CONV_S (6) -> COMMIT (1) -> IDLE.
//   Request seen at cycle t -> bcd_valid at t+21. busy=1 from CAP through COMMIT.
//   If pending is set at COMMIT, the FSM goes directly to CAP.
//  Double-dabble: 8-bit BCD scratch per field; add 3 to any nibble >=5 before each shift.
//  Range check per field: hrs>99 -> H1=H0=4'hE; min>59 -> M1=M0=4'hE; sec>59 -> S1=S0=4'hE;
//   fmt_err = OR of the three checks. bcd_digits and fmt_err update only at COMMIT.
//   The display never shows a partially converted frame.
//  Scan: divider counts 0..SCAN_DIV-1; on wrap the scan index advances 0..5 and wraps to 0.
//   digit_sel = 1<<index (index 0 = S0). seg_out/dp_out are registered, aligned with digit_sel.
//  Decode: 0-9 standard; 4'hE = 'E' (7'b1111001 active-high); any other code -> all off.
//   Active-low variants invert all bits.
//  Colon: phase toggles on every half_sec_pulse. dp lit on index 4 (H0) and 2 (M0) when phase=1.
//  blank=1: digit_sel=0, seg/dp off on the next cycle. Scan counters and conversion keep running.
// CONFIGURATION
//  HMS_LZ_BLANK_EN defined: if H1==0, digit 5 shows all segments off (dp unaffected).
//  HMS_LZ_BLANK_EN undefined: H1==0 shows '0'. bcd_digits is identical in both builds.
// TESTING
//  1 reset; hms_time={1'b0,7'd12,6'd34,6'd56}; sec_pulse at cycle t -> bcd_valid at t+21,
//    bcd_digits=24'h123456, fmt_err=0.
//  2 SCAN_DIV=4, blank=0, digits 123456 -> digit_sel steps 000001,000010,..,100000 every 4 cycles.
//    At 100000, seg_out=~7'b0000110 ('1', active-low).
//  3 hms_time hrs=7'd100, min=59, sec=0 -> bcd_digits=24'hEE5900, fmt_err=1; 'E' shown on digits 5,4.
//  4 sec_pulse at t, and 3 more sec_pulses during that conversion -> exactly two bcd_valid pulses;
//    the second is 21 cycles after the first.
//  5 half_sec_pulse x2 -> dp on H0/M0 goes off then on. reset asserted at CONV_M ->
//    busy=0, bcd_digits=0, no bcd_valid.
//  6 HMS_LZ_BLANK_EN defined, hrs=5 -> at digit_sel=100000 seg_out=7'b1111111 (off, active-low);
//    bcd_digits[23:20]=0.

Source files
------------

// File: rtl/hms_display_driver.sv
// HH:MM:SS driver: sequential double-dabble BCD conversion plus a multiplexed 6-digit 7-segment scan.
// Optional HMS_LZ_BLANK_EN: blank the hours-tens digit when it is zero.
module hms_display_driver #(
    parameter int unsigned SCAN_DIV       = 4,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [19:0] hms_time,
    input  logic        half_sec_pulse,
    input  logic        sec_pulse,
    input  logic        blank,
    output logic [6:0]  seg_out,
    output logic        dp_out,
    output logic [5:0]  digit_sel,
    output logic [23:0] bcd_digits,
    output logic        bcd_valid,
    output logic        fmt_err,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_CAP, S_CONV_H, S_CONV_M, S_CONV_S, S_COMMIT
    } state_t;

    state_t      state;
    logic [19:0] shadow;
    logic        pending;
    logic [7:0]  scratch;
    logic [2:0]  cnt;
    logic [7:0]  h_bcd;
    logic [7:0]  m_bcd;
    logic        cur_bit;
    logic [7:0]  dd_next;
    logic [6:0]  hrs;
    logic [5:0]  mins;
    logic [5:0]  secs;

    function automatic logic [7:0] dd_step(input logic [7:0] s, input logic b);
        logic [7:0] a;
        a = s;
        if (a[3:0] >= 4'd5) a[3:0] = a[3:0] + 4'd3;
        if (a[7:4] >= 4'd5) a[7:4] = a[7:4] + 4'd3;
        return {a[6:0], b};
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] c);
        case (c)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            4'hE:    return 7'h79;
            default: return 7'h00;
        endcase
    endfunction

    assign hrs  = shadow[18:12];
    assign mins = shadow[11:6];
    assign secs = shadow[5:0];

    always_comb begin
        cur_bit = 1'b0;
        case (state)
            S_CONV_H: cur_bit = hrs[3'd6 - cnt];
            S_CONV_M: cur_bit = mins[3'd5 - cnt];
            S_CONV_S: cur_bit = secs[3'd5 - cnt];
            default:  cur_bit = 1'b0;
        endcase
        dd_next = dd_step(scratch, cur_bit);
    end

    // The commit is registered on the final seconds shift so bcd_valid is high during COMMIT.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            shadow     <= '0;
            pending    <= 1'b1;
            scratch    <= '0;
            cnt        <= '0;
            h_bcd      <= '0;
            m_bcd      <= '0;
            bcd_digits <= '0;
            bcd_valid  <= 1'b0;
            fmt_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            bcd_valid <= 1'b0;
            if (sec_pulse) pending <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (pending || sec_pulse || (hms_time != shadow)) begin
                        state   <= S_CAP;
                        pending <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                S_CAP: begin
                    shadow  <= hms_time;
                    scratch <= '0;
                    cnt     <= '0;
                    state   <= S_CONV_H;
                end
                S_CONV_H: begin
                    scratch <= dd_next;
                    cnt     <= cnt + 3'd1;
                    if (cnt == 3'd6) begin
                        h_bcd   <= dd_next;
                        scratch <= '0;
                        cnt     <= '0;
                        state   <= S_CONV_M;
                    end
                end
                S_CONV_M: begin
                    scratch <= dd_next;
                    cnt     <= cnt + 3'd1;
                    if (cnt == 3'd5) begin
                        m_bcd   <= dd_next;
                        scratch <= '0;
                        cnt     <= '0;
                        state   <= S_CONV_S;
                    end
                end
                S_CONV_S: begin
                    scratch <= dd_next;
                    cnt     <= cnt + 3'd1;
                    if (cnt == 3'd5) begin
                        bcd_digits <= {(hrs > 7'd99)  ? 8'hEE : h_bcd,
                                       (mins > 6'd59) ? 8'hEE : m_bcd,
                                       (secs > 6'd59) ? 8'hEE : dd_next};
                        fmt_err    <= (hrs > 7'd99) || (mins > 6'd59) || (secs > 6'd59);
                        bcd_valid  <= 1'b1;
                        state      <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    if (pending || sec_pulse) begin
                        state   <= S_CAP;
                        pending <= 1'b0;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    logic [15:0] div_cnt;
    logic [2:0]  idx;
    logic        phase;
    logic [3:0]  code;
    logic [6:0]  seg_hi;
    logic        dp_lit;

    always_comb begin
        code   = bcd_digits[{idx, 2'b00} +: 4];
        seg_hi = seg_decode(code);
`ifdef HMS_LZ_BLANK_EN
        if (idx == 3'd5 && code == 4'd0) seg_hi = '0;
`endif
        dp_lit = phase && (idx == 3'd4 || idx == 3'd2);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt   <= '0;
            idx       <= '0;
            phase     <= 1'b1;
            digit_sel <= '0;
            seg_out   <= {7{SEG_ACTIVE_LOW}};
            dp_out    <= SEG_ACTIVE_LOW;
        end else begin
            if (div_cnt == 16'(SCAN_DIV - 1)) begin
                div_cnt <= '0;
                idx     <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            end else begin
                div_cnt <= div_cnt + 16'd1;
            end
            if (half_sec_pulse) phase <= ~phase;
            if (blank) begin
                digit_sel <= '0;
                seg_out   <= {7{SEG_ACTIVE_LOW}};
                dp_out    <= SEG_ACTIVE_LOW;
            end else begin
                digit_sel <= 6'b000001 << idx;
                seg_out   <= seg_hi ^ {7{SEG_ACTIVE_LOW}};
                dp_out    <= dp_lit ^ SEG_ACTIVE_LOW;
            end
        end
    end

endmodule

// File: tb/tb_hms_display_driver.sv
// Scoreboarded bench for hms_display_driver: directed time words, scan/decode, colon, blank, reset abort.
module tb_hms_display_driver;

    logic        clock;
    logic        reset;
    logic [19:0] hms_time;
    logic        half_sec_pulse;
    logic        sec_pulse;
    logic        blank;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [5:0]  digit_sel;
    logic [23:0] bcd_digits;
    logic        bcd_valid;
    logic        fmt_err;
    logic        busy;

    hms_display_driver #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clock(clock), .reset(reset), .hms_time(hms_time),
        .half_sec_pulse(half_sec_pulse), .sec_pulse(sec_pulse), .blank(blank),
        .seg_out(seg_out), .dp_out(dp_out), .digit_sel(digit_sel),
        .bcd_digits(bcd_digits), .bcd_valid(bcd_valid), .fmt_err(fmt_err), .busy(busy)
    );

    typedef struct {
        logic [23:0] digits;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    int   tests  = 0;
    int   failed = 0;
    int   cyc    = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic push(input logic [23:0] d, input logic e, input int c);
        exp_t x;
        x.digits = d;
        x.err    = e;
        x.cyc    = c;
        sbq.push_back(x);
    endtask

    task automatic pulse_sec(output int t);
        t = cyc;
        sec_pulse = 1'b1;
        tick(1);
        sec_pulse = 1'b0;
    endtask

    task automatic wait_sel(input logic [5:0] sel, input string name);
        int n;
        n = 0;
        @(negedge clock);
        while (digit_sel !== sel && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (digit_sel !== sel) check(name, {26'd0, digit_sel}, {26'd0, sel});
    endtask

    // Monitor: every bcd_valid pulse must match the oldest expected commit, including its cycle.
    initial begin
        forever begin
            @(negedge clock);
            if (bcd_valid === 1'b1) begin
                if (sbq.size() == 0) begin
                    check("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("bcd_digits", {8'd0, bcd_digits}, {8'd0, e.digits});
                    check("fmt_err", {31'd0, fmt_err}, {31'd0, e.err});
                    check("valid_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    logic [6:0] exp_seg [6];
    logic [5:0] prev_sel;
    int t;
    int r;
    bit synced;

    initial begin
        exp_seg[0] = 7'h02; exp_seg[1] = 7'h12; exp_seg[2] = 7'h19;
        exp_seg[3] = 7'h30; exp_seg[4] = 7'h24; exp_seg[5] = 7'h79;
        reset = 1'b1; half_sec_pulse = 1'b0; sec_pulse = 1'b0; blank = 1'b0;
        hms_time = {1'b0, 7'd12, 6'd34, 6'd56};

        // Reset values
        tick(3);
        @(negedge clock);
        check("rst_bcd_digits", {8'd0, bcd_digits}, 32'd0);
        check("rst_bcd_valid", {31'd0, bcd_valid}, 32'd0);
        check("rst_fmt_err", {31'd0, fmt_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_digit_sel", {26'd0, digit_sel}, 32'd0);
        check("rst_seg_out", {25'd0, seg_out}, 32'h7F);
        check("rst_dp_out", {31'd0, dp_out}, 32'd1);
        tick(1);
        reset = 1'b0;
        r = cyc;
        push(24'h123456, 1'b0, r + 21);
        tick(25);

        // Explicit sec_pulse conversion, latency and busy
        check("idle_busy", {31'd0, busy}, 32'd0);
        pulse_sec(t);
        push(24'h123456, 1'b0, t + 21);
        tick(4);
        @(negedge clock);
        check("conv_busy", {31'd0, busy}, 32'd1);
        tick(25);

        // Scan order and decode of 123456
        synced = 1'b0;
        prev_sel = digit_sel;
        for (int n = 0; n < 60 && !synced; n++) begin
            @(negedge clock);
            if (digit_sel === 6'b000001 && prev_sel === 6'b100000) synced = 1'b1;
            prev_sel = digit_sel;
        end
        check("scan_sync", {31'd0, synced}, 32'd1);
        for (int k = 0; k < 24; k++) begin
            if (k > 0) @(negedge clock);
            check("scan_digit_sel", {26'd0, digit_sel}, 32'd1 << (k / 4));
            if (k % 4 == 0) begin
                check("scan_seg", {25'd0, seg_out}, {25'd0, exp_seg[k / 4]});
                check("scan_dp", {31'd0, dp_out},
                      ((k / 4) == 4 || (k / 4) == 2) ? 32'd0 : 32'd1);
            end
        end

        // Out-of-range hours
        tick(1);
        hms_time = {1'b0, 7'd100, 6'd59, 6'd0};
        pulse_sec(t);
        push(24'hEE5900, 1'b1, t + 21);
        tick(25);
        wait_sel(6'b100000, "wait_d5_err");
        check("err_seg_d5", {25'd0, seg_out}, 32'h06);
        wait_sel(6'b010000, "wait_d4_err");
        check("err_seg_d4", {25'd0, seg_out}, 32'h06);

        // Leading zero on hours tens
        tick(1);
        hms_time = {1'b0, 7'd5, 6'd6, 6'd7};
        pulse_sec(t);
        push(24'h050607, 1'b0, t + 21);
        tick(25);
        check("lz_bcd_h1", {28'd0, bcd_digits[23:20]}, 32'd0);
        wait_sel(6'b100000, "wait_d5_lz");
`ifdef HMS_LZ_BLANK_EN
        check("lz_seg_d5", {25'd0, seg_out}, 32'h7F);
`else
        check("lz_seg_d5", {25'd0, seg_out}, 32'h40);
`endif

        // Merged requests: four pulses during one conversion yield two commits
        tick(1);
        t = cyc;
        push(24'h050607, 1'b0, t + 21);
        push(24'h050607, 1'b0, t + 42);
        for (int k = 0; k < 22; k++) begin
            sec_pulse = (k == 0 || k == 3 || k == 8 || k == 15);
            tick(1);
        end
        sec_pulse = 1'b0;
        tick(30);
        check("merge_idle_busy", {31'd0, busy}, 32'd0);

        // Blank
        blank = 1'b1;
        tick(2);
        @(negedge clock);
        check("blank_digit_sel", {26'd0, digit_sel}, 32'd0);
        check("blank_seg", {25'd0, seg_out}, 32'h7F);
        check("blank_dp", {31'd0, dp_out}, 32'd1);
        tick(1);
        blank = 1'b0;

        // Colon blink on H0
        half_sec_pulse = 1'b1;
        tick(1);
        half_sec_pulse = 1'b0;
        tick(2);
        wait_sel(6'b010000, "wait_colon_off");
        check("colon_off", {31'd0, dp_out}, 32'd1);
        tick(1);
        half_sec_pulse = 1'b1;
        tick(1);
        half_sec_pulse = 1'b0;
        tick(2);
        wait_sel(6'b010000, "wait_colon_on");
        check("colon_on", {31'd0, dp_out}, 32'd0);

        // Reset during CONV_M aborts without commit
        tick(1);
        hms_time = {1'b0, 7'd1, 6'd2, 6'd3};
        pulse_sec(t);
        tick(9);
        @(negedge clock);
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick(2);
        @(negedge clock);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_bcd_digits", {8'd0, bcd_digits}, 32'd0);
        check("abort_bcd_valid", {31'd0, bcd_valid}, 32'd0);
        tick(1);
        reset = 1'b0;
        r = cyc;
        push(24'h010203, 1'b0, r + 21);
        tick(25);

        for (int n = 0; n < 50 && sbq.size() != 0; n++) tick(1);
        check("scoreboard_empty", sbq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
